dht11_bcd_conv: RTL and testbench
=================================

// Module: dht11_bcd_conv
// PURPOSE
// - Consumer of the DHT11 driver's 32-bit result {hum_int, hum_frac, temp_int, temp_frac}.
// - On each new reading: snapshot it, convert both integer bytes to 3-digit BCD, clamp fractions to one digit.
// - Also produces temperature sign and hysteretic high-humidity/high-temperature alarms for the nano_viewer display path.
// PARAMETERS
// - HUM_HI    default 8'd80  humidity alarm set threshold, %RH integer
// - TEMP_HI   default 8'd40  temperature alarm set threshold, degC integer
// - HYST      default 8'd2   alarm clear hysteresis; clear when value < THRESH-HYST (saturating at 0)
// PORTS
// - dht11_clk    in   1   1 MHz operating clock
// - sys_rst_n    in   1   async active-low reset
// - dht11_data   in   32  [31:24] hum int, [23:16] hum frac, [15:8] temp int, [7] temp sign, [6:0] temp frac
// - hum_bcd      out  12  humidity integer, 3 BCD digits (hundreds,tens,ones)
// - hum_frac     out  4   humidity fraction digit 0..9
// - temp_bcd     out  12  temperature integer magnitude, 3 BCD digits
// - temp_frac    out  4   temperature fraction digit 0..9
// - temp_neg     out  1   1 = temperature negative
// - hum_alarm    out  1   humidity alarm level
// - temp_alarm   out  1   temperature alarm level
// - data_valid   out  1   1-cycle pulse: all outputs above updated this cycle
// - data_ready   out  1   level: at least one conversion completed since reset
// - busy         out  1   conversion in progress
// BEHAVIOUR
// - Reset: all outputs 0; snap_r=0; pending=0; FSM=IDLE.
// - Input is held (not strobed) and has no reset upstream: change detect is dht11_data != snap_r.
// - An X or all-zero input never triggers.
// - FSM IDLE: on change at edge E0: snap_r<=dht11_data; start pulse to both converters; ->CONV; busy=1.
// - FSM CONV: wait for converter done (both finish together) -> UPDATE.
// - FSM UPDATE: register all outputs from snap_r and converter results; data_valid=1 for exactly this cycle.
//   - If pending=1: clear it, ->IDLE (change re-detected next cycle); else ->IDLE.
// - Latency: outputs and data_valid change at edge E0+11 (1 load + 8 shift + 1 done + 1 update). busy high E0+1..E0+11.
// - Input changing during CONV/UPDATE: pending<=1; the in-flight conversion completes on the old snapshot.
//   - A later reading is converted immediately after. Readings are never merged mid-conversion.
// - Fractions: hum_frac = (byte>9)?9:byte[3:0]; temp_frac from [6:0] with the same clamp.
// - temp_neg = snap_r[7]; temp_bcd is magnitude only.
// - Alarms, evaluated in UPDATE on snapshot integers:
//   - set when value >= HI.
//   - clear when value < HI-HYST; otherwise hold.
//   - temp_alarm: a negative temperature always clears.
// - data_ready sets at first UPDATE; cleared only by reset.
// - Reset mid-conversion: everything returns to reset values; next change is processed from IDLE.
// - Arithmetic: double-dabble; each digit nibble +3 when >=5 before each shift. 8-bit in, 12-bit out. Max 255 -> 0x255.
// STRUCTURE
// - Shared include dht11_defs.vh:
//   - FSM encodings (IDLE/CONV/UPDATE).
//   - Field slice localparams for dht11_data.
//   - BCD_W=12, FRAC_MAX=9.
// - Sub-module bin8_to_bcd3, instantiated twice (hum, temp). Sequential, one bit per clock.
//   - Ports: clk, rst_n, start, bin[7:0], bcd[11:0], done.
//   - start loads the shift register; 8 shift cycles; done pulses one cycle.
//   - bcd is held until the next start.
// - Top: change detect, snapshot, pending flag, FSM, clamps, alarm registers.
// TESTING
// - Reset release, dht11_data=0 held 100 cycles -> data_valid never pulses, data_ready=0, all outputs 0.
// - dht11_data=32'h3F05_1903 (63.5%, 25.3C) at E0 -> at E0+11:
//   - hum_bcd=12'h063, hum_frac=5, temp_bcd=12'h025, temp_frac=3, temp_neg=0.
//   - data_valid single pulse, data_ready=1.
// - Humidity 8'd80 -> hum_alarm=1.
//   - Then 79 and 78 -> stays 1.
//   - Then 77 -> clears to 0 at that update.
// - Change to 32'hFF0C_0A8F -> hum_bcd=12'h255, hum_frac=9 (clamped), temp_bcd=12'h010, temp_neg=1, temp_frac=9, temp_alarm=0.
// - Second value applied at E0+4 during CONV -> first value appears at E0+11.
//   - Second value appears at E0+23. Exactly two data_valid pulses.
// - Assert sys_rst_n low at E0+5 -> outputs 0 and busy=0 immediately.
//   - After release with the same input held -> full conversion 11 cycles after first post-reset edge.

Source files
------------

// File: rtl/dht11_bcd_conv_pkg.sv
// Shared types, field positions and arithmetic helpers for the DHT11 reading-to-BCD path.
package dht11_bcd_conv_pkg;

    localparam int         BCD_W         = 12;
    localparam logic [3:0] FRAC_MAX      = 4'd9;
    localparam int         HUM_INT_LSB   = 24;
    localparam int         HUM_FRAC_LSB  = 16;
    localparam int         TEMP_INT_LSB  = 8;
    localparam int         TEMP_SIGN_BIT = 7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_UPDATE = 2'd2
    } state_t;

    // One double-dabble step on {bcd[11:0], bin[7:0]}: adjust digits, then shift.
    function automatic logic [19:0] dd_step(input logic [19:0] s);
        logic [19:0] a;
        a = s;
        a[11:8]  = (a[11:8]  >= 4'd5) ? a[11:8]  + 4'd3 : a[11:8];
        a[15:12] = (a[15:12] >= 4'd5) ? a[15:12] + 4'd3 : a[15:12];
        a[19:16] = (a[19:16] >= 4'd5) ? a[19:16] + 4'd3 : a[19:16];
        return {a[18:0], 1'b0};
    endfunction

    function automatic logic [3:0] frac_clamp(input logic [7:0] b);
        return (b > 8'd9) ? FRAC_MAX : b[3:0];
    endfunction

    // Alarm clear level, saturating at zero when the hysteresis exceeds the threshold.
    function automatic logic [7:0] clr_level(input logic [7:0] hi, input logic [7:0] hyst);
        return (hi > hyst) ? (hi - hyst) : 8'd0;
    endfunction

endpackage

// File: rtl/dht11_bcd_conv_bin8_to_bcd3.sv
// Sequential 8-bit binary to 3-digit BCD converter, one double-dabble step per clock.
module bin8_to_bcd3
    import dht11_bcd_conv_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       bin,
    output logic [BCD_W-1:0] bcd,
    output logic             done
);

    logic [19:0] sh_q;
    logic [2:0]  cnt_q;
    logic        run_q;
    logic [19:0] step_s;

    assign step_s = dd_step(sh_q);

    // Load on start, run eight steps, publish the result together with the done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q  <= 20'd0;
            cnt_q <= 3'd0;
            run_q <= 1'b0;
            bcd   <= 12'd0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                sh_q  <= {12'd0, bin};
                cnt_q <= 3'd0;
                run_q <= 1'b1;
            end else if (run_q) begin
                sh_q  <= step_s;
                cnt_q <= cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    run_q <= 1'b0;
                    done  <= 1'b1;
                    bcd   <= step_s[19:8];
                end
            end
        end
    end

endmodule

// File: rtl/dht11_bcd_conv.sv
// Snapshots each new DHT11 reading, converts it to BCD display fields and keeps
// hysteretic humidity/temperature alarms.
module dht11_bcd_conv
    import dht11_bcd_conv_pkg::*;
#(
    parameter logic [7:0] HUM_HI  = 8'd80,
    parameter logic [7:0] TEMP_HI = 8'd40,
    parameter logic [7:0] HYST    = 8'd2
) (
    input  logic             dht11_clk,
    input  logic             sys_rst_n,
    input  logic [31:0]      dht11_data,
    output logic [BCD_W-1:0] hum_bcd,
    output logic [3:0]       hum_frac,
    output logic [BCD_W-1:0] temp_bcd,
    output logic [3:0]       temp_frac,
    output logic             temp_neg,
    output logic             hum_alarm,
    output logic             temp_alarm,
    output logic             data_valid,
    output logic             data_ready,
    output logic             busy
);

    localparam logic [7:0] HUM_LO  = clr_level(HUM_HI, HYST);
    localparam logic [7:0] TEMP_LO = clr_level(TEMP_HI, HYST);

    state_t            state_q;
    logic [31:0]       snap_q;
    logic              start_q;
    logic              pending_q;
    logic              change_s;
    logic [7:0]        hum_int_s;
    logic [7:0]        temp_int_s;
    logic [BCD_W-1:0]  hum_conv_s;
    logic [BCD_W-1:0]  temp_conv_s;
    logic              hum_done_s;
    logic              temp_done_s;

    // The source is held, unreset and may be X: only a known, non-zero, new word counts.
    assign change_s   = !$isunknown(dht11_data) && (dht11_data != 32'd0) && (dht11_data != snap_q);
    assign hum_int_s  = snap_q[HUM_INT_LSB +: 8];
    assign temp_int_s = snap_q[TEMP_INT_LSB +: 8];

    bin8_to_bcd3 u_hum_conv (
        .clk   (dht11_clk),
        .rst_n (sys_rst_n),
        .start (start_q),
        .bin   (hum_int_s),
        .bcd   (hum_conv_s),
        .done  (hum_done_s)
    );

    bin8_to_bcd3 u_temp_conv (
        .clk   (dht11_clk),
        .rst_n (sys_rst_n),
        .start (start_q),
        .bin   (temp_int_s),
        .bcd   (temp_conv_s),
        .done  (temp_done_s)
    );

    // Sequencer: snapshot, wait for both converters, then publish all outputs at once.
    always_ff @(posedge dht11_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_IDLE;
            snap_q     <= 32'd0;
            start_q    <= 1'b0;
            pending_q  <= 1'b0;
            hum_bcd    <= 12'd0;
            hum_frac   <= 4'd0;
            temp_bcd   <= 12'd0;
            temp_frac  <= 4'd0;
            temp_neg   <= 1'b0;
            hum_alarm  <= 1'b0;
            temp_alarm <= 1'b0;
            data_valid <= 1'b0;
            data_ready <= 1'b0;
            busy       <= 1'b0;
        end else begin
            start_q    <= 1'b0;
            data_valid <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (change_s) begin
                        snap_q  <= dht11_data;
                        start_q <= 1'b1;
                        busy    <= 1'b1;
                        state_q <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    pending_q <= pending_q | change_s;
                    if (hum_done_s && temp_done_s) begin
                        state_q <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    hum_bcd    <= hum_conv_s;
                    temp_bcd   <= temp_conv_s;
                    hum_frac   <= frac_clamp(snap_q[HUM_FRAC_LSB +: 8]);
                    temp_frac  <= frac_clamp({1'b0, snap_q[6:0]});
                    temp_neg   <= snap_q[TEMP_SIGN_BIT];
                    hum_alarm  <= (hum_int_s >= HUM_HI) ? 1'b1 :
                                  (hum_int_s < HUM_LO)  ? 1'b0 : hum_alarm;
                    temp_alarm <= snap_q[TEMP_SIGN_BIT]  ? 1'b0 :
                                  (temp_int_s >= TEMP_HI) ? 1'b1 :
                                  (temp_int_s < TEMP_LO)  ? 1'b0 : temp_alarm;
                    data_valid <= 1'b1;
                    data_ready <= 1'b1;
                    busy       <= 1'b0;
                    pending_q  <= 1'b0;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dht11_bcd_conv.sv
// Vector table plus hand sequences for dht11_bcd_conv; results checked through a queue scoreboard.
`timescale 1ns/1ps
module tb_dht11_bcd_conv;

    logic        dht11_clk;
    logic        sys_rst_n;
    logic [31:0] dht11_data;
    logic [11:0] hum_bcd, temp_bcd;
    logic [3:0]  hum_frac, temp_frac;
    logic        temp_neg, hum_alarm, temp_alarm, data_valid, data_ready, busy;

    typedef struct {
        logic [31:0] data;
        logic [11:0] hb;
        logic [3:0]  hf;
        logic [11:0] tb;
        logic [3:0]  tf;
        logic        tn;
        logic        ha;
        logic        ta;
    } vec_t;

    vec_t vecs[10];
    vec_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   n_valid = 0;

    dht11_bcd_conv dut (
        .dht11_clk  (dht11_clk),
        .sys_rst_n  (sys_rst_n),
        .dht11_data (dht11_data),
        .hum_bcd    (hum_bcd),
        .hum_frac   (hum_frac),
        .temp_bcd   (temp_bcd),
        .temp_frac  (temp_frac),
        .temp_neg   (temp_neg),
        .hum_alarm  (hum_alarm),
        .temp_alarm (temp_alarm),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .busy       (busy)
    );

    initial dht11_clk = 1'b0;
    always #500 dht11_clk = ~dht11_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] d, input logic [11:0] hb, input logic [3:0] hf,
                                input logic [11:0] tb, input logic [3:0] tf,
                                input logic tn, input logic ha, input logic ta);
        vec_t v;
        v.data = d; v.hb = hb; v.hf = hf; v.tb = tb; v.tf = tf; v.tn = tn; v.ha = ha; v.ta = ta;
        return v;
    endfunction

    // Scoreboard: every data_valid pulse pops one expected record.
    always @(posedge dht11_clk) begin
        vec_t e;
        #1;
        if (data_valid === 1'b1) begin
            n_valid++;
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("hum_bcd",    {20'd0, hum_bcd},   {20'd0, e.hb});
                check("hum_frac",   {28'd0, hum_frac},  {28'd0, e.hf});
                check("temp_bcd",   {20'd0, temp_bcd},  {20'd0, e.tb});
                check("temp_frac",  {28'd0, temp_frac}, {28'd0, e.tf});
                check("temp_neg",   {31'd0, temp_neg},  {31'd0, e.tn});
                check("hum_alarm",  {31'd0, hum_alarm}, {31'd0, e.ha});
                check("temp_alarm", {31'd0, temp_alarm},{31'd0, e.ta});
                check("data_ready", {31'd0, data_ready}, 32'd1);
            end
        end
    end

    task automatic check_all_zero(input string name);
        check(name, {hum_bcd, hum_frac, temp_bcd, temp_frac, temp_neg, hum_alarm,
                     temp_alarm, data_valid, data_ready, busy}, 32'd0);
    endtask

    // Drive one vector just before E0 and measure edges from E0 to the data_valid sample.
    task automatic apply_vec(input vec_t v);
        int k;
        int nv0;
        @(negedge dht11_clk);
        dht11_data = v.data;
        exp_q.push_back(v);
        nv0 = n_valid;
        k = 0;
        while (n_valid == nv0 && k <= 40) begin
            @(posedge dht11_clk);
            #2;
            k++;
            if (k == 6) check("busy_mid_conv", {31'd0, busy}, 32'd1);
        end
        check("latency_after_e0", k - 1, 32'd11);
        @(posedge dht11_clk);
        #2;
        check("valid_single_pulse", {31'd0, data_valid}, 32'd0);
        check("busy_after_update", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int k, k1, k2, nv0;
        #(5_000_000);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int k, k1, k2, nv0;
        vecs[0] = mk(32'h3F05_1903, 12'h063, 4'd5, 12'h025, 4'd3, 1'b0, 1'b0, 1'b0);
        vecs[1] = mk(32'h5000_2800, 12'h080, 4'd0, 12'h040, 4'd0, 1'b0, 1'b1, 1'b1);
        vecs[2] = mk(32'h4F00_2700, 12'h079, 4'd0, 12'h039, 4'd0, 1'b0, 1'b1, 1'b1);
        vecs[3] = mk(32'h4E00_2600, 12'h078, 4'd0, 12'h038, 4'd0, 1'b0, 1'b1, 1'b1);
        vecs[4] = mk(32'h4D00_2500, 12'h077, 4'd0, 12'h037, 4'd0, 1'b0, 1'b0, 1'b0);
        vecs[5] = mk(32'h5000_2800, 12'h080, 4'd0, 12'h040, 4'd0, 1'b0, 1'b1, 1'b1);
        vecs[6] = mk(32'hFF0C_0A8F, 12'h255, 4'd9, 12'h010, 4'd9, 1'b1, 1'b1, 1'b0);
        vecs[7] = mk(32'h6407_6309, 12'h100, 4'd7, 12'h099, 4'd9, 1'b0, 1'b1, 1'b1);
        vecs[8] = mk(32'h0000_0001, 12'h000, 4'd0, 12'h000, 4'd1, 1'b0, 1'b0, 1'b0);
        vecs[9] = mk(32'h0A0A_2809, 12'h010, 4'd9, 12'h040, 4'd9, 1'b0, 1'b0, 1'b1);

        sys_rst_n  = 1'b0;
        dht11_data = 'x;
        repeat (3) @(posedge dht11_clk);
        #1;
        check_all_zero("reset_state");

        // Unknown then all-zero input must never start a conversion.
        @(negedge dht11_clk);
        sys_rst_n = 1'b1;
        repeat (20) @(posedge dht11_clk);
        @(negedge dht11_clk);
        dht11_data = 32'd0;
        repeat (100) @(posedge dht11_clk);
        #2;
        check("idle_no_valid", n_valid, 32'd0);
        check_all_zero("idle_outputs");

        for (int i = 0; i < 10; i++) apply_vec(vecs[i]);

        // Second reading lands during CONV: both emerge, in order, without merging.
        @(negedge dht11_clk);
        dht11_data = 32'h1E00_1400;
        exp_q.push_back(mk(32'h1E00_1400, 12'h030, 4'd0, 12'h020, 4'd0, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(32'h5A03_3201, 12'h090, 4'd3, 12'h050, 4'd1, 1'b0, 1'b1, 1'b1));
        nv0 = n_valid;
        k = 0; k1 = -1; k2 = -1;
        while (n_valid < nv0 + 2 && k <= 60) begin
            @(posedge dht11_clk);
            #2;
            k++;
            if (k == 4) begin
                @(negedge dht11_clk);
                dht11_data = 32'h5A03_3201;
            end
            if (n_valid == nv0 + 1 && k1 < 0) k1 = k;
            if (n_valid == nv0 + 2 && k2 < 0) k2 = k;
        end
        check("pend_first_latency", k1 - 1, 32'd11);
        check("pend_second_latency", k2 - 1, 32'd23);
        repeat (30) @(posedge dht11_clk);
        #2;
        check("pend_exactly_two", n_valid - nv0, 32'd2);

        // Reset in the middle of a conversion, then reconvert the held input.
        @(negedge dht11_clk);
        dht11_data = 32'h2D04_1E02;
        repeat (5) @(posedge dht11_clk);
        @(negedge dht11_clk);
        sys_rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid_conv");
        exp_q.delete();
        @(negedge dht11_clk);
        sys_rst_n = 1'b1;
        exp_q.push_back(mk(32'h2D04_1E02, 12'h045, 4'd4, 12'h030, 4'd2, 1'b0, 1'b0, 1'b0));
        nv0 = n_valid;
        k = 0;
        while (n_valid == nv0 && k <= 40) begin
            @(posedge dht11_clk);
            #2;
            k++;
        end
        check("post_reset_latency", k - 1, 32'd11);
        repeat (20) @(posedge dht11_clk);
        #2;
        check("post_reset_one_valid", n_valid - nv0, 32'd1);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
